// File: rtl/baton_beat_detector.sv
// rtl/baton_beat_detector.sv - smoothed baton turning-point beat detector
// Moving-average smoothing, hysteresis peak/valley FSM, beat period measurement.
module baton_beat_detector #(
   parameter int WIDTH    = 11,
   parameter int AVG_LOG2 = 2,
   parameter int DEADBAND = 4,
   parameter int HOLDOFF  = 500000,
   parameter int PERIOD_W = 24
) (
   input  logic                clk_camera_in,
   input  logic                rst_n_in,
   input  logic                valid_in,
   input  logic [WIDTH-1:0]    y_com_in,
   input  logic [1:0]          mode_in,
   output logic                beat_out,
   output logic                beat_dir_out,
   output logic [PERIOD_W-1:0] period_out,
   output logic                period_valid_out,
   output logic [7:0]          beat_count_out,
   output logic [WIDTH-1:0]    smooth_y_out
);
   localparam int N     = 1 << AVG_LOG2;
   localparam int SUM_W = WIDTH + AVG_LOG2;
   localparam logic signed [WIDTH:0] DB       = (WIDTH+1)'(DEADBAND);
   localparam logic signed [WIDTH:0] ZERO     = '0;
   localparam logic [AVG_LOG2:0]     FILL_MAX = (AVG_LOG2+1)'(N);
   localparam logic [PERIOD_W-1:0]   ELAPSED_MAX = '1;
   localparam logic [1:0] ST_WARMUP = 2'd0, ST_SEEK = 2'd1, ST_RISING = 2'd2, ST_FALLING = 2'd3;

   logic                in_valid_q;
   logic [WIDTH-1:0]    in_y_q;
   logic [WIDTH-1:0]    buf_q [N];
   logic [AVG_LOG2-1:0] wr_ptr_q;
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic [AVG_LOG2:0]   fill_q;
   logic                sm_valid_q;
   logic [WIDTH-1:0]    smooth_q, smooth_d;

   logic [1:0]          state_q, state_d;
   logic [WIDTH-1:0]    ref_q, ref_d, ext_q, ext_d;
   logic signed [WIDTH:0] diff_ref, diff_ext;
   logic                ev, ev_dir, permit, hold_ok, report;
   logic [PERIOD_W-1:0] elapsed_q, period_q;
   logic                first_q, beat_q, dir_q, pv_q;
   logic [7:0]          count_q;

   assign sum_d    = sum_q + SUM_W'(in_y_q) - SUM_W'(buf_q[wr_ptr_q]);
   assign smooth_d = sum_d[SUM_W-1:AVG_LOG2];

   // Stage 0 registers the raw sample, stage 1 folds it into the window sum.
   always_ff @(posedge clk_camera_in) begin
      if (!rst_n_in) begin
         in_valid_q <= 1'b0;
         in_y_q     <= '0;
         for (int i = 0; i < N; i++) buf_q[i] <= '0;
         wr_ptr_q   <= '0;
         sum_q      <= '0;
         fill_q     <= '0;
         sm_valid_q <= 1'b0;
         smooth_q   <= '0;
      end else begin
         in_valid_q <= valid_in;
         in_y_q     <= y_com_in;
         sm_valid_q <= in_valid_q;
         if (in_valid_q) begin
            buf_q[wr_ptr_q] <= in_y_q;
            wr_ptr_q        <= wr_ptr_q + AVG_LOG2'(1);
            sum_q           <= sum_d;
            smooth_q        <= smooth_d;
            if (fill_q != FILL_MAX) fill_q <= fill_q + (AVG_LOG2+1)'(1);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ref_d    = ref_q;
      ext_d    = ext_q;
      ev       = 1'b0;
      ev_dir   = 1'b0;
      diff_ref = $signed({1'b0, smooth_q}) - $signed({1'b0, ref_q});
      diff_ext = $signed({1'b0, smooth_q}) - $signed({1'b0, ext_q});
      if (sm_valid_q) begin
         case (state_q)
            ST_WARMUP: begin
               if (fill_q == FILL_MAX) begin
                  state_d = ST_SEEK;
                  ref_d   = smooth_q;
               end
            end
            ST_SEEK: begin
               if (diff_ref >= DB) begin
                  state_d = ST_RISING;
                  ext_d   = smooth_q;
               end else if (-diff_ref >= DB) begin
                  state_d = ST_FALLING;
                  ext_d   = smooth_q;
               end
            end
            ST_RISING: begin
               if (diff_ext > ZERO) begin
                  ext_d = smooth_q;
               end else if (-diff_ext >= DB) begin
                  ev      = 1'b1;
                  ev_dir  = 1'b1;
                  state_d = ST_FALLING;
                  ext_d   = smooth_q;
               end
            end
            default: begin
               if (diff_ext < ZERO) begin
                  ext_d = smooth_q;
               end else if (diff_ext >= DB) begin
                  ev      = 1'b1;
                  ev_dir  = 1'b0;
                  state_d = ST_RISING;
                  ext_d   = smooth_q;
               end
            end
         endcase
      end
   end

   always_comb begin
      case (mode_in)
         2'd0:    permit = !ev_dir;
         2'd1:    permit = ev_dir;
         2'd2:    permit = 1'b1;
         default: permit = 1'b0;
      endcase
      hold_ok = first_q || (64'(elapsed_q) >= 64'(HOLDOFF));
      report  = ev && permit && hold_ok;
   end

   // Unreported turns still steer the FSM but leave counters untouched.
   always_ff @(posedge clk_camera_in) begin
      if (!rst_n_in) begin
         state_q   <= ST_WARMUP;
         ref_q     <= '0;
         ext_q     <= '0;
         elapsed_q <= '0;
         first_q   <= 1'b1;
         beat_q    <= 1'b0;
         dir_q     <= 1'b0;
         period_q  <= '0;
         pv_q      <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q <= state_d;
         ref_q   <= ref_d;
         ext_q   <= ext_d;
         beat_q  <= report;
         pv_q    <= report && !first_q;
         if (report) begin
            dir_q     <= ev_dir;
            period_q  <= elapsed_q;
            count_q   <= count_q + 8'd1;
            first_q   <= 1'b0;
            elapsed_q <= PERIOD_W'(1);
         end else if (elapsed_q != ELAPSED_MAX) begin
            elapsed_q <= elapsed_q + PERIOD_W'(1);
         end
      end
   end

   assign beat_out         = beat_q;
   assign beat_dir_out     = dir_q;
   assign period_out       = period_q;
   assign period_valid_out = pv_q;
   assign beat_count_out   = count_q;
   assign smooth_y_out     = smooth_q;
endmodule
